// File: rtl/alu_muldiv_seq_pkg.sv
// Shared ALU definitions: muldiv opcodes, sequencer states, special-case result fills.
// Opcode values follow funct3 order under a common M-extension prefix.
package alu_muldiv_seq_pkg;

  localparam int OP_W  = 11;
  localparam int CNT_W = 6;

  localparam logic [OP_W-1:0] OP_MUL    = 11'h100;
  localparam logic [OP_W-1:0] OP_MULH   = 11'h101;
  localparam logic [OP_W-1:0] OP_MULHSU = 11'h102;
  localparam logic [OP_W-1:0] OP_MULHU  = 11'h103;
  localparam logic [OP_W-1:0] OP_DIV    = 11'h104;
  localparam logic [OP_W-1:0] OP_DIVU   = 11'h105;
  localparam logic [OP_W-1:0] OP_REM    = 11'h106;
  localparam logic [OP_W-1:0] OP_REMU   = 11'h107;

  // Divide-by-zero quotient is all-ones; signed-overflow remainder is all-zeros.
  localparam logic DIVZ_QUO_BIT = 1'b1;
  localparam logic OVF_REM_BIT  = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic op_is_div(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic op_is_signed_div(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [OP_W-1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request/response bundle between the issue stage and the muldiv sequencer.
// Request is valid/ready; response is held until resp_ready.
interface alu_muldiv_seq_if
  import alu_muldiv_seq_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [OP_W-1:0]  req_op;
  logic [XLEN-1:0]  req_a;
  logic [XLEN-1:0]  req_b;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_result;
  logic [TAG_W-1:0] resp_tag;

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_tag
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, resp_ready,
    output req_ready, resp_valid, resp_result, resp_tag
  );
endinterface

// File: rtl/alu_muldiv_seq_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
// Purely combinational; no backpressure.
module muldiv_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            dvd_bit_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_bit_o
);
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // rem_i < dvs_i, so shifted < 2*dvs_i and the borrow lands in the top bit.
  assign shifted = {rem_i, dvd_bit_i};
  assign diff    = shifted - {1'b0, dvs_i};
  assign q_bit_o = ~diff[XLEN];
  assign rem_o   = q_bit_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];
endmodule

// File: rtl/alu_muldiv_seq.sv
// Sequential mul/div unit: multiply and divide special cases in 1 cycle, divide in XLEN cycles.
// Single outstanding op; result held in DONE until resp_ready; flush squashes any state.
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  output logic            busy,
  alu_muldiv_seq_if.slave bus
);
  state_e             state_q, state_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [XLEN-1:0]    a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]    rem_q, rem_d, quo_q, quo_d, res_q, res_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               in_sgn, in_ovf, in_one_cycle;
  logic [XLEN-1:0]    in_a_mag;
  logic               sgn, a_neg, b_neg;
  logic [XLEN-1:0]    b_mag, step_rem, quo_next, quo_fix, rem_fix, one_res;
  logic               step_qbit;
  logic [2*XLEN-1:0]  a_ext, b_ext, prod;

  assign in_sgn       = op_is_signed_div(bus.req_op);
  assign in_ovf       = in_sgn && (bus.req_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.req_b == '1);
  assign in_one_cycle = !op_is_div(bus.req_op) || (bus.req_b == '0) || in_ovf;
  assign in_a_mag     = (in_sgn && bus.req_a[XLEN-1]) ? -bus.req_a : bus.req_a;

  assign sgn   = op_is_signed_div(op_q);
  assign a_neg = sgn && a_q[XLEN-1];
  assign b_neg = sgn && b_q[XLEN-1];
  assign b_mag = b_neg ? -b_q : b_q;

  muldiv_div_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (quo_q[XLEN-1]),
    .dvs_i     (b_mag),
    .rem_o     (step_rem),
    .q_bit_o   (step_qbit)
  );

  assign quo_next = {quo_q[XLEN-2:0], step_qbit};
  assign quo_fix  = (a_neg ^ b_neg) ? -quo_next : quo_next;
  assign rem_fix  = a_neg ? -step_rem : step_rem;

  // Sign-extending to 2*XLEN makes the truncated product exact for every signedness mix.
  assign a_ext = {{XLEN{((op_q == OP_MULH) || (op_q == OP_MULHSU)) && a_q[XLEN-1]}}, a_q};
  assign b_ext = {{XLEN{(op_q == OP_MULH) && b_q[XLEN-1]}}, b_q};
  assign prod  = a_ext * b_ext;

  // S_MUL doubles as the single-cycle result state for div special cases and unknown ops.
  always_comb begin
    one_res = '0;
    case (op_q)
      OP_MUL:                       one_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: one_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              one_res = (b_q == '0) ? {XLEN{DIVZ_QUO_BIT}} : a_q;
      OP_REM, OP_REMU:              one_res = (b_q == '0) ? a_q : {XLEN{OVF_REM_BIT}};
      default:                      one_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    res_d   = res_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && !flush) begin
          op_d    = bus.req_op;
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          tag_d   = bus.req_tag;
          quo_d   = in_a_mag;
          rem_d   = '0;
          cnt_d   = CNT_W'(XLEN-1);
          state_d = in_one_cycle ? S_MUL : S_DIV;
        end
      end
      S_MUL: begin
        res_d   = one_res;
        state_d = S_DONE;
      end
      S_DIV: begin
        rem_d = step_rem;
        quo_d = quo_next;
        if (cnt_q == '0) begin
          res_d   = op_is_rem(op_q) ? rem_fix : quo_fix;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      res_q   <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req_ready   = (state_q == S_IDLE) && !flush;
  assign bus.resp_valid  = (state_q == S_DONE);
  assign bus.resp_result = res_q;
  assign bus.resp_tag    = tag_q;
  assign busy            = (state_q != S_IDLE);
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomized and directed checks of alu_muldiv_seq against an arithmetic reference model.
// A negedge monitor compares every valid response against the expected-result queue.
module tb_alu_muldiv_seq;
  import alu_muldiv_seq_pkg::*;

  localparam int XLEN  = 64;
  localparam int TAG_W = 5;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic busy;
  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  alu_muldiv_seq_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  alu_muldiv_seq #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [10:0] op, input logic [63:0] a,
                                        input logic [63:0] b);
    longint              sa, sb;
    logic signed [127:0] wa, wb, p;
    logic [127:0]        ua, ub, up;
    sa = a;
    sb = b;
    wa = sa;
    wb = sb;
    ua = {64'd0, a};
    ub = {64'd0, b};
    case (op)
      OP_MUL:    return a * b;
      OP_MULH:   begin p = wa * wb;          return p[127:64]; end
      OP_MULHU:  begin up = ua * ub;         return up[127:64]; end
      OP_MULHSU: begin p = wa * $signed(ub); return p[127:64]; end
      OP_DIV: begin
        if (b == 0) return ONES;
        if (a == MINV && b == ONES) return a;
        return sa / sb;
      end
      OP_DIVU:   return (b == 0) ? ONES : a / b;
      OP_REM: begin
        if (b == 0) return a;
        if (a == MINV && b == ONES) return 64'd0;
        return sa % sb;
      end
      OP_REMU:   return (b == 0) ? a : a % b;
      default:   return 64'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [10:0] op, input logic [63:0] a, input logic [63:0] b);
    logic is_div, sgn;
    is_div = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    sgn    = (op == OP_DIV) || (op == OP_REM);
    if (!is_div || b == 0 || (sgn && a == MINV && b == ONES)) return 1;
    return XLEN;
  endfunction

  // Called at posedge+1 with the DUT idle; returns the result seen on the first valid cycle.
  task automatic run_op(input logic [10:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] tag, input int hold, output logic [63:0] got);
    int   lat;
    exp_t e;
    chk("req_ready_idle", {63'd0, bus.req_ready}, 64'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
    e.res = model(op, a, b);
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 11'($urandom);
    bus.req_a     = {$urandom, $urandom};
    bus.req_b     = {$urandom, $urandom};
    bus.req_tag   = 5'($urandom);
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    lat = 0;
    while (!bus.resp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat(op, a, b)));
    got = bus.resp_result;
    for (int i = 0; i < hold; i++) begin
      chk("req_ready_in_done", {63'd0, bus.req_ready}, 64'd0);
      chk("busy_in_done", {63'd0, busy}, 64'd1);
      chk("result_stable", bus.resp_result, got);
      chk("tag_stable", {59'd0, bus.resp_tag}, {59'd0, tag});
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("resp_valid_after_take", {63'd0, bus.resp_valid}, 64'd0);
    chk("req_ready_after_take", {63'd0, bus.req_ready}, 64'd1);
  endtask

  always @(negedge clk) begin
    if (!reset && bus.resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_resp_valid", 64'd1, 64'd0);
      end else begin
        chk("mon_result", bus.resp_result, exp_q[0].res);
        chk("mon_tag", {59'd0, bus.resp_tag}, {59'd0, exp_q[0].tag});
      end
    end
  end

  always @(posedge clk) begin
    if (!reset && !flush && bus.resp_valid && bus.resp_ready && exp_q.size() > 0)
      void'(exp_q.pop_front());
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]  got;
    int           seen;
    logic [10:0]  ops[8];
    logic [10:0]  op;
    logic [63:0]  a, b;
    ops = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};

    reset = 1'b1;
    flush = 1'b0;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    bus.req_op     = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_tag    = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    chk("rst_result", bus.resp_result, 64'd0);
    chk("rst_tag", {59'd0, bus.resp_tag}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);

    // Hand-computed values pinning the reference model.
    chk("model_mulh", model(OP_MULH, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3), ONES);
    chk("model_div", model(OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("model_rem", model(OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2), ONES);
    chk("model_mulhu", model(OP_MULHU, ONES, ONES), 64'hFFFF_FFFF_FFFF_FFFE);
    chk("model_mul", model(OP_MUL, 64'd6, 64'd7), 64'd42);

    run_op(OP_MULH, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'd1, 0, got);
    chk("dut_mulh", got, ONES);
    run_op(OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd2, 0, got);
    chk("dut_div", got, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd3, 0, got);
    chk("dut_rem", got, ONES);
    run_op(OP_DIVU, 64'd5, 64'd0, 5'd4, 0, got);
    chk("dut_divu_zero", got, ONES);
    run_op(OP_REMU, 64'd5, 64'd0, 5'd5, 0, got);
    chk("dut_remu_zero", got, 64'd5);
    run_op(OP_DIV, MINV, ONES, 5'd6, 0, got);
    chk("dut_div_ovf", got, MINV);
    run_op(OP_REM, MINV, ONES, 5'd7, 10, got);
    chk("dut_rem_ovf", got, 64'd0);
    run_op(11'h7FF, 64'd9, 64'd9, 5'd8, 0, got);
    chk("dut_unsupported", got, 64'd0);

    // Flush at iteration 30 of a DIVU, with a simultaneous request present.
    bus.req_valid = 1'b1;
    bus.req_op    = OP_DIVU;
    bus.req_a     = 64'h1234_5678_9ABC_DEF0;
    bus.req_b     = 64'd77;
    bus.req_tag   = 5'd9;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1 flush = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = OP_MUL;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.req_valid = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    seen = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (bus.resp_valid) seen++;
    end
    chk("flush_no_resp", 64'(seen), 64'd0);
    run_op(OP_MUL, 64'd6, 64'd7, 5'd10, 0, got);
    chk("mul_after_flush", got, 64'd42);

    // Flush in IDLE blocks a simultaneous request.
    flush = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = OP_MUL;
    #1 chk("flush_req_ready", {63'd0, bus.req_ready}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    bus.req_valid = 1'b0;
    chk("flush_idle_not_accepted", {63'd0, busy}, 64'd0);

    // Reset in the middle of a DIV discards the operation.
    bus.req_valid = 1'b1;
    bus.req_op    = OP_DIV;
    bus.req_a     = 64'hFFFF_FFFF_FFFF_FF9C;
    bus.req_b     = 64'd7;
    bus.req_tag   = 5'd11;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    chk("midrst_result", bus.resp_result, 64'd0);
    chk("midrst_tag", {59'd0, bus.resp_tag}, 64'd0);
    seen = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (bus.resp_valid) seen++;
    end
    chk("midrst_no_resp", 64'(seen), 64'd0);
    run_op(OP_MUL, 64'd6, 64'd7, 5'd12, 0, got);
    chk("mul_after_reset", got, 64'd42);

    // Randomized ops with mixed corner operands and response stalls.
    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 11'($urandom) : ops[$urandom_range(0, 7)];
      case ($urandom_range(0, 5))
        0:       a = MINV;
        1:       a = ONES;
        2:       a = 64'($urandom_range(0, 100));
        default: a = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 6))
        0:       b = 64'd0;
        1:       b = ONES;
        2:       b = 64'($urandom_range(1, 50));
        3:       b = {32'd0, $urandom};
        default: b = {$urandom, $urandom};
      endcase
      run_op(op, a, b, 5'($urandom), $urandom_range(0, 3), got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_muldiv_seq.md
ALU_MULDIV_SEQ -- requirements
Module: alu_muldiv_seq

Interface
REQ-001 SHALL have parameter XLEN, default 64: operand/result width.
REQ-002 SHALL have parameter TAG_W, default 5: destination-register tag width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  pipeline squash; aborts any in-flight operation.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  block accepts a request this cycle.
REQ-008 SHALL have port req_op  input  11  ALU opcode: MUL, MULH, MULHU, MULHSU, DIV, DIVU, REM or REMU.
REQ-009 SHALL have port req_a, req_b  input  XLEN  operands: rs1, rs2.
REQ-010 SHALL have port req_tag  input  TAG_W  destination tag, returned unchanged.
REQ-011 SHALL have port resp_valid  output  1  result held and valid.
REQ-012 SHALL have port resp_ready  input  1  consumer takes the result.
REQ-013 SHALL have port resp_result  output  XLEN  result; resp_tag  output  TAG_W  captured tag.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE; drives the decode stall.

Function
REQ-015 SHALL implement the states IDLE, MUL, DIV and DONE.
REQ-016 SHALL drive req_ready = (state==IDLE) && !flush, with no combinational path from resp_ready.
REQ-017 SHALL register the operands, op and tag on handshake edge k and move to MUL (multiply ops) or DIV (divide/remainder ops).
REQ-018 SHALL, in MUL, form the 128-bit product with signed/unsigned operand handling per op, store low XLEN bits (MUL) or high XLEN bits (MULH/MULHU/MULHSU), and enter DONE at edge k+1.
REQ-019 SHALL, in DIV, run a restoring divider on operand magnitudes for exactly XLEN iterations (6-bit counter, XLEN-1 down to 0), one quotient bit per cycle, and enter DONE at edge k+XLEN.
REQ-020 SHALL apply signed fixup on the final iteration: quotient negated if the operand signs differ; remainder carries the dividend's sign.
REQ-021 SHALL, for divide by zero, skip DIV and enter DONE at edge k+1 with quotient all-ones and remainder = req_a.
REQ-022 SHALL, for signed overflow (a = -2^(XLEN-1), b = -1), skip DIV and enter DONE at edge k+1 with quotient = a and remainder 0.
REQ-023 SHALL treat an unsupported op as one-cycle, result 0.
REQ-024 SHALL hold resp_valid, resp_result and resp_tag stable in DONE until resp_ready, then return to IDLE on that edge; the next request is accepted one cycle later at the earliest.
REQ-025 SHALL have flush override every other event in any state: next state IDLE, resp_valid low next cycle, no response issued, and a simultaneous request not accepted.

Reset
REQ-026 SHALL, on reset, set state IDLE, counter 0, and resp_valid, resp_result, resp_tag and busy to 0; reset takes priority over flush and the handshakes, and may occur mid-operation with the result discarded.

Structure
REQ-027 SHALL take the opcode constants from the shared ALU definitions package and place the state enum and divide-by-zero/overflow result constants there.
REQ-028 SHALL instantiate one sub-module, muldiv_div_step: a combinational single-iteration shift/subtract returning the new partial remainder and quotient bit.

Verification
REQ-029 SHALL verify: MULH a=-2, b=3 -> resp_result all-ones, resp_valid one cycle after accept.
REQ-030 SHALL verify: DIV a=-7, b=2 -> quotient -3, resp_valid 64 cycles after accept; REM same operands -> -1.
REQ-031 SHALL verify: DIVU a=5, b=0 -> 0xFFFF_FFFF_FFFF_FFFF after 1 cycle; REMU -> 5.
REQ-032 SHALL verify: DIV a=0x8000_0000_0000_0000, b=-1 -> 0x8000_0000_0000_0000; REM -> 0.
REQ-033 SHALL verify: resp_ready held low 10 cycles after DONE -> result and tag stable, req_ready low, busy high.
REQ-034 SHALL verify: flush at iteration 30 of DIVU, or reset mid-DIV -> IDLE next cycle, no resp_valid, and the following MUL 6*7 returns 42.
